// File: rtl/alu_op_sequencer.sv
// Command sequencer for the calculator ALU: operand resolution,
// multi-step shift/power iteration, accumulator and flag ownership.
module alu_op_sequencer #(
   parameter int DATA_W = 8,
   parameter int RES_W  = 16,
   parameter int OPC_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OPC_W-1:0]  cmd_opcode,
   input  logic [DATA_W-1:0] cmd_reg,
   input  logic [DATA_W-1:0] cmd_imm,
   input  logic              cmd_use_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] alu_c,
   output logic [OPC_W-1:0]  alu_opcode,
   input  logic [RES_W-1:0]  alu_result,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              alu_cy,
   input  logic              alu_o,
   output logic [RES_W-1:0]  res_out,
   output logic              res_valid,
   output logic [DATA_W-1:0] acc_out,
   output logic [3:0]        flags_out,
   output logic              err_div0,
   output logic              err_illegal
);

   localparam logic [OPC_W-1:0] OP_FIRST = OPC_W'(8'h09);
   localparam logic [OPC_W-1:0] OP_LAST  = OPC_W'(8'h21);
   localparam logic [OPC_W-1:0] OP_LSR   = OPC_W'(8'h0B);
   localparam logic [OPC_W-1:0] OP_LSL   = OPC_W'(8'h0C);
   localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(8'h10);
   localparam logic [OPC_W-1:0] OP_DIV   = OPC_W'(8'h11);
   localparam logic [OPC_W-1:0] OP_MOD   = OPC_W'(8'h12);
   localparam logic [OPC_W-1:0] OP_CMP   = OPC_W'(8'h17);
   localparam logic [OPC_W-1:0] OP_TST   = OPC_W'(8'h18);
   localparam logic [OPC_W-1:0] OP_POW   = OPC_W'(8'h1D);
   localparam int               PAD_W    = RES_W - DATA_W;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t            state;
   logic [OPC_W-1:0]  op_q;
   logic [DATA_W-1:0] cnt;
   logic              ovf;

   logic [DATA_W-1:0] op_b;
   logic              zb;
   logic              is_shift;
   logic              is_pow;
   logic              c_ill;
   logic              c_div0;
   logic              c_sh0;
   logic              c_pw0;
   logic              c_sh;
   logic              c_pw;
   logic [DATA_W-1:0] step_lo;
   logic              step_hi;
   logic              q_pow;
   logic              q_keep_acc;

   assign alu_c = acc_out;

   always_comb begin
      op_b     = cmd_use_imm ? cmd_imm : acc_out;
      zb       = (op_b == '0);
      is_shift = (cmd_opcode == OP_LSL) || (cmd_opcode == OP_LSR);
      is_pow   = (cmd_opcode == OP_POW);
      c_ill    = (cmd_opcode < OP_FIRST) || (cmd_opcode > OP_LAST);
      c_div0   = ((cmd_opcode == OP_DIV) || (cmd_opcode == OP_MOD)) && zb;
      c_sh0    = is_shift && zb;
      c_pw0    = is_pow && zb;
      c_sh     = is_shift && !zb;
      c_pw     = is_pow && !zb;
      step_lo  = alu_result[DATA_W-1:0];
      step_hi  = |alu_result[RES_W-1:DATA_W];
      q_pow    = (op_q == OP_POW);
      q_keep_acc = (op_q == OP_CMP) || (op_q == OP_TST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cmd_ready   <= 1'b1;
         res_valid   <= 1'b0;
         res_out     <= '0;
         acc_out     <= '0;
         flags_out   <= '0;
         err_div0    <= 1'b0;
         err_illegal <= 1'b0;
         alu_opcode  <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         op_q        <= '0;
         cnt         <= '0;
         ovf         <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  op_q      <= cmd_opcode;
                  cnt       <= (is_shift || is_pow) ? op_b : DATA_W'(1);
                  ovf       <= 1'b0;
                  unique case (1'b1)
                     c_ill: begin
                        state       <= DONE;
                        res_valid   <= 1'b1;
                        err_illegal <= 1'b1;
                        res_out     <= '0;
                     end
                     c_div0: begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        err_div0  <= 1'b1;
                        res_out   <= '1;
                     end
                     c_sh0: begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_out   <= {{PAD_W{1'b0}}, cmd_reg};
                        flags_out <= {cmd_reg == '0, 3'b000};
                        acc_out   <= cmd_reg;
                     end
                     c_pw0: begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_out   <= RES_W'(1);
                        flags_out <= '0;
                        acc_out   <= DATA_W'(1);
                     end
                     c_sh: begin
                        state      <= EXEC;
                        alu_a      <= cmd_reg;
                        alu_b      <= DATA_W'(1);
                        alu_opcode <= cmd_opcode;
                     end
                     c_pw: begin
                        state      <= EXEC;
                        alu_a      <= DATA_W'(1);
                        alu_b      <= cmd_reg;
                        alu_opcode <= OP_MUL;
                     end
                     default: begin
                        state      <= EXEC;
                        alu_a      <= cmd_reg;
                        alu_b      <= op_b;
                        alu_opcode <= cmd_opcode;
                     end
                  endcase
               end
            end
            EXEC: begin
               cnt <= cnt - 1'b1;
               if (cnt > DATA_W'(1)) begin
                  // chain the low byte of this step into the next issue
                  alu_a <= step_lo;
                  ovf   <= ovf | step_hi;
               end else begin
                  state      <= DONE;
                  res_valid  <= 1'b1;
                  alu_opcode <= '0;
                  if (q_pow) begin
                     res_out   <= {{PAD_W{1'b0}}, step_lo};
                     flags_out <= {step_lo == '0, 2'b00, ovf | step_hi};
                     acc_out   <= step_lo;
                  end else begin
                     res_out   <= alu_result;
                     flags_out <= {alu_z, alu_n, alu_cy, alu_o};
                     if (!q_keep_acc) acc_out <= step_lo;
                  end
               end
            end
            DONE: begin
               state       <= IDLE;
               cmd_ready   <= 1'b1;
               res_valid   <= 1'b0;
               err_div0    <= 1'b0;
               err_illegal <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU stub plus a
// command-level reference model, directed and random commands.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_opcode;
   logic [7:0]  cmd_reg;
   logic [7:0]  cmd_imm;
   logic        cmd_use_imm;
   logic [7:0]  alu_a, alu_b, alu_c;
   logic [5:0]  alu_opcode;
   logic [15:0] alu_result;
   logic        alu_z, alu_n, alu_cy, alu_o;
   logic [15:0] res_out;
   logic        res_valid;
   logic [7:0]  acc_out;
   logic [3:0]  flags_out;
   logic        err_div0;
   logic        err_illegal;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  m_acc;
   logic [3:0]  m_flags;
   int          e_lat, e_iss;
   logic [7:0]  e_b1;
   logic [15:0] e_res;
   logic        e_d0, e_ill;
   logic [7:0]  e_acc;
   logic [3:0]  e_flags;
   logic [7:0]  a_hist[$];
   logic [5:0]  op_tab[12];

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_reg(cmd_reg),
      .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .alu_opcode(alu_opcode), .alu_result(alu_result),
      .alu_z(alu_z), .alu_n(alu_n), .alu_cy(alu_cy), .alu_o(alu_o),
      .res_out(res_out), .res_valid(res_valid),
      .acc_out(acc_out), .flags_out(flags_out),
      .err_div0(err_div0), .err_illegal(err_illegal)
   );

   // simple combinational ALU: {result, z, n, c, o}
   function automatic logic [19:0] alu_eval(
      input logic [5:0] op, input logic [7:0] a,
      input logic [7:0] b, input logic [7:0] c);
      logic [15:0] r;
      logic [8:0]  s;
      logic        cy, ov, ng;
      r = 16'h0; cy = 1'b0; ov = 1'b0;
      case (op)
         6'h09: begin
            s = {1'b0, a} + {1'b0, b}; r = {8'h00, s[7:0]}; cy = s[8];
            ov = (a[7] == b[7]) && (s[7] != a[7]);
         end
         6'h0A, 6'h17: begin
            s = {1'b0, a} - {1'b0, b}; r = {8'h00, s[7:0]}; cy = s[8];
            ov = (a[7] != b[7]) && (s[7] != a[7]);
         end
         6'h0B: begin r = {8'h00, 1'b0, a[7:1]}; cy = a[0]; end
         6'h0C: begin r = {8'h00, a[6:0], 1'b0}; cy = a[7]; end
         6'h0F: r = {8'h00, a};
         6'h10: begin r = 16'(a) * 16'(b); ov = |r[15:8]; end
         6'h11: r = (b == 0) ? 16'hFFFF : 16'(a / b);
         6'h12: r = (b == 0) ? 16'hFFFF : 16'(a % b);
         6'h18: r = {8'h00, a & b};
         6'h00: r = 16'h0;
         default: r = {8'h00, a ^ b ^ c};
      endcase
      ng = (op == 6'h10) ? r[15] : r[7];
      return {r, r == 16'h0, ng, cy, ov};
   endfunction

   always_comb
      {alu_result, alu_z, alu_n, alu_cy, alu_o} =
         alu_eval(alu_opcode, alu_a, alu_b, alu_c);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // command-level reference model
   task automatic model(input logic [5:0] op, input logic [7:0] r,
                        input logic [7:0] imm, input logic ui);
      int n, p, prod;
      logic [7:0]  x, opb;
      logic [19:0] v;
      logic        o;
      opb = ui ? imm : m_acc;
      n = int'(opb);
      e_d0 = 0; e_ill = 0; e_acc = m_acc; e_flags = m_flags;
      e_b1 = 0; e_iss = 0; e_lat = 1;
      if (op < 6'h09 || op > 6'h21) begin
         e_ill = 1; e_res = 16'h0;
      end else if ((op == 6'h11 || op == 6'h12) && opb == 0) begin
         e_d0 = 1; e_res = 16'hFFFF;
      end else if (op == 6'h0B || op == 6'h0C) begin
         if (n == 0) begin
            e_res = {8'h00, r}; e_flags = {r == 0, 3'b000}; e_acc = r;
         end else begin
            x = r; v = '0;
            for (int i = 0; i < n; i++) begin
               v = alu_eval(op, x, 8'd1, m_acc);
               x = v[11:4];
            end
            e_res = v[19:4]; e_flags = v[3:0]; e_acc = x;
            e_lat = n + 1; e_iss = n; e_b1 = 8'd1;
         end
      end else if (op == 6'h1D) begin
         p = 1; o = 0;
         for (int i = 0; i < n; i++) begin
            prod = p * int'(r);
            if (prod > 255) o = 1;
            p = prod % 256;
         end
         e_res = 16'(p); e_acc = 8'(p);
         e_flags = {p == 0, 2'b00, o};
         e_iss = n;
         if (n > 0) begin e_lat = n + 1; e_b1 = r; end
      end else begin
         v = alu_eval(op, r, opb, m_acc);
         e_res = v[19:4]; e_flags = v[3:0];
         if (op != 6'h17 && op != 6'h18) e_acc = v[11:4];
         e_lat = 2; e_iss = 1; e_b1 = opb;
      end
   endtask

   task automatic run_cmd(input logic [5:0] op, input logic [7:0] r,
                          input logic [7:0] imm, input logic ui);
      int lat, iss;
      logic [7:0] b1;
      model(op, r, imm, ui);
      a_hist.delete();
      @(negedge clk);
      cmd_valid = 1; cmd_opcode = op; cmd_reg = r;
      cmd_imm = imm; cmd_use_imm = ui;
      chk("ready_idle", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1 cmd_valid = 0;
      lat = 0; iss = 0; b1 = 0;
      while (lat < 400) begin
         @(negedge clk);
         lat++;
         if (alu_opcode != 0) begin
            if (iss == 0) b1 = alu_b;
            a_hist.push_back(alu_a);
            iss++;
         end
         if (res_valid) break;
      end
      chk("latency", 32'(lat), 32'(e_lat));
      chk("issues", 32'(iss), 32'(e_iss));
      chk("first_b", 32'(b1), 32'(e_b1));
      chk("res_out", 32'(res_out), 32'(e_res));
      chk("err_div0", 32'(err_div0), 32'(e_d0));
      chk("err_illegal", 32'(err_illegal), 32'(e_ill));
      chk("ready_busy", 32'(cmd_ready), 32'd0);
      chk("alu_nop_done", 32'(alu_opcode), 32'd0);
      @(negedge clk);
      chk("valid_drop", 32'(res_valid), 32'd0);
      chk("ready_back", 32'(cmd_ready), 32'd1);
      chk("err_clear", 32'({err_div0, err_illegal}), 32'd0);
      chk("acc_out", 32'(acc_out), 32'(e_acc));
      chk("flags_out", 32'(flags_out), 32'(e_flags));
      m_acc = e_acc; m_flags = e_flags;
   endtask

   initial begin
      logic [5:0] op;
      logic [7:0] r, imm;
      logic       ui;
      logic       seen;
      op_tab = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h10,
                 6'h11, 6'h12, 6'h17, 6'h18, 6'h1D, 6'h00};
      rst = 1; cmd_valid = 0; cmd_opcode = 0; cmd_reg = 0;
      cmd_imm = 0; cmd_use_imm = 0;
      m_acc = 0; m_flags = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_acc", 32'(acc_out), 32'd0);
      chk("rst_flags", 32'(flags_out), 32'd0);
      chk("rst_aluop", 32'(alu_opcode), 32'd0);
      chk("rst_res", 32'(res_out), 32'd0);

      run_cmd(6'h0F, 8'h05, 8'h00, 1'b1);
      run_cmd(6'h09, 8'h03, 8'h77, 1'b0);
      chk("add_res", 32'(res_out), 32'h0008);
      chk("add_acc", 32'(acc_out), 32'h08);
      run_cmd(6'h1D, 8'd3, 8'd4, 1'b1);
      chk("pow_a0", 32'(a_hist[0]), 32'd1);
      chk("pow_a1", 32'(a_hist[1]), 32'd3);
      chk("pow_a2", 32'(a_hist[2]), 32'd9);
      chk("pow_a3", 32'(a_hist[3]), 32'd27);
      chk("pow_res", 32'(res_out), 32'h0051);
      run_cmd(6'h1D, 8'd2, 8'd9, 1'b1);
      chk("pow_ovf_flags", 32'(flags_out), 32'b1001);
      run_cmd(6'h0C, 8'h81, 8'd1, 1'b1);
      chk("lsl_c", 32'(flags_out[1]), 32'd1);
      run_cmd(6'h0C, 8'h81, 8'd0, 1'b1);
      run_cmd(6'h11, 8'h10, 8'd0, 1'b1);
      run_cmd(6'h3F, 8'h12, 8'h34, 1'b1);
      run_cmd(6'h17, 8'd4, 8'd4, 1'b1);
      chk("cmp_z", 32'(flags_out[3]), 32'd1);
      run_cmd(6'h0B, 8'hF0, 8'd5, 1'b1);
      run_cmd(6'h1D, 8'd1, 8'd255, 1'b1);

      for (int k = 0; k < 40; k++) begin
         int idx;
         idx = $urandom_range(0, 11);
         op = (idx == 11) ? 6'($urandom) : op_tab[idx];
         r = 8'($urandom);
         if (op == 6'h0B || op == 6'h0C || op == 6'h1D) begin
            imm = 8'($urandom_range(0, 9));
            ui = ($urandom_range(0, 3) != 0);
         end else begin
            imm = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            ui = 1'($urandom);
         end
         run_cmd(op, r, imm, ui);
      end

      run_cmd(6'h0F, 8'hA5, 8'h01, 1'b1);
      @(negedge clk);
      cmd_valid = 1; cmd_opcode = 6'h1D; cmd_reg = 8'd3;
      cmd_imm = 8'd200; cmd_use_imm = 1;
      @(posedge clk);
      #1 cmd_valid = 0;
      repeat (3) @(negedge clk);
      chk("abort_issuing", 32'(alu_opcode), 32'h10);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      chk("abort_valid", 32'(res_valid), 32'd0);
      chk("abort_acc", 32'(acc_out), 32'd0);
      chk("abort_flags", 32'(flags_out), 32'd0);
      chk("abort_aluop", 32'(alu_opcode), 32'd0);
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (res_valid) seen = 1;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      m_acc = 0; m_flags = 0;
      run_cmd(6'h09, 8'h10, 8'h22, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-level controller in front of the combinational ALU of the pocket-calculator core.
- Accepts one operation per valid/ready handshake, resolves the second operand (immediate or accumulator) and drives the ALU ports.
- Iterates multi-step operations (LSL/LSR by n, POW by n) through repeated single-step ALU issues.
- Owns the 8-bit accumulator and the registered Z/N/C/O flags.

Parameters:
- DATA_W, 8, operand/accumulator width
- RES_W, 16, ALU result width
- OPC_W, 6, opcode width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_opcode  in  OPC_W  operation code, ALU encoding
- cmd_reg  in  DATA_W  register operand (ALU a)
- cmd_imm  in  DATA_W  immediate operand / iteration count
- cmd_use_imm  in  1  1: operand b = cmd_imm; 0: operand b = accumulator
- alu_a, alu_b, alu_c  out  DATA_W  ALU operand drive (alu_c = accumulator always)
- alu_opcode  out  OPC_W  ALU opcode drive
- alu_result  in  RES_W  ALU result
- alu_z, alu_n, alu_cy, alu_o  in  1  ALU flags
- res_out  out  RES_W  registered final result
- res_valid  out  1  one-cycle result strobe
- acc_out  out  DATA_W  accumulator
- flags_out  out  4  {Z,N,C,O}, registered
- err_div0  out  1  divide/modulo by zero, valid with res_valid
- err_illegal  out  1  unsupported opcode, valid with res_valid

Behaviour:
- Reset: state IDLE; cmd_ready=1; res_valid=0; res_out=0; acc_out=0; flags_out=0; err_*=0; alu_opcode=0; alu_a/alu_b=0; iteration counter=0.
- Reset asserted mid-operation aborts it. No res_valid is issued and the accumulator returns to 0.
- Handshake:
  - Accept in IDLE when cmd_valid && cmd_ready; command fields are latched.
  - cmd_ready=1 only in IDLE.
  - cmd_valid outside IDLE is ignored; the requester holds it.
- Operand resolution at accept: opB = cmd_use_imm ? cmd_imm : acc_out.
- States:
  - IDLE -> EXEC (normal op) or DONE (zero count, div0, illegal).
  - EXEC -> EXEC while counter > 1; otherwise -> DONE.
  - DONE -> IDLE.
- res_valid=1 exactly in DONE.
- Single-step ops (opcodes 0x09-0x21 except 0x0B, 0x0C, 0x1D):
  - One EXEC cycle with alu_a=reg, alu_b=opB, alu_opcode=opcode.
  - alu_result and flags are captured at the end of EXEC.
  - res_valid appears 2 cycles after accept.
- LSL (0x0C) / LSR (0x0B) by n=opB:
  - Each EXEC issues the shift with alu_b=1; alu_a = previous result[7:0], starting from reg.
  - C comes from the last step.
  - n EXEC cycles; res_valid at cycle n+1.
- POW (0x1D) by n=opB:
  - Partial p starts at 1; each EXEC issues MUL (0x10) with alu_a=p, alu_b=reg.
  - p <= alu_result[7:0].
  - O is sticky-set if any step has alu_result[15:8] != 0.
  - res_out={8'h00,p}; Z=(p==0); N=0; C=0.
- n=0 for LSL/LSR/POW: no ALU issue, DONE next cycle (res_valid at cycle 1).
  - Shift: res_out=reg, flags Z=(reg==0), N=C=O=0.
  - POW: res_out=1, flags all 0.
- DIV (0x11) / MOD (0x12) with opB==0:
  - No ALU issue, DONE next cycle.
  - err_div0=1, res_out=16'hFFFF.
  - acc_out and flags_out unchanged.
- Opcode outside 0x09-0x21:
  - No ALU issue, DONE next cycle.
  - err_illegal=1, res_out=0.
  - acc_out and flags_out unchanged.
- Accumulator: acc_out <= final result[7:0] in DONE for every successful op except CMP (0x17) and TST (0x18). Those two update flags only; res_out is still driven.
- Flags: flags_out is written in DONE for successful ops only.
- Outside EXEC: alu_opcode=0 (NOP); alu_a/alu_b hold their last values.
- err_* clear in the cycle after DONE.
- Iteration counter is 8 bits and loads opB at accept. n=255 takes 255 EXEC cycles; no wrap.

Test Plan:
- Reset -> cmd_ready=1, res_valid=0, acc_out=0x00, flags_out=4'b0000, alu_opcode=0.
- MOV (0x0F) reg=0x05, then ADD (0x09) reg=0x03 use_imm=0:
  - MOV: res_valid at cycle 2, acc_out=0x05.
  - ADD: alu_b=0x05, res_out=0x0008, acc_out=0x08, Z=0.
- POW reg=3 imm=4 use_imm=1 -> 4 MUL issues with alu_a=1,3,9,27; res_valid at cycle 5; res_out=0x0051; O=0.
- POW reg=2 imm=9 -> res_out=0x0000; Z=1; O=1.
- LSL reg=0x81 imm=1 -> res_out low byte 0x02, C=1.
- LSL reg=0x81 imm=0 -> res_valid at cycle 1, res_out=0x0081, no ALU issue.
- DIV reg=0x10 imm=0 -> err_div0=1, res_out=0xFFFF, acc_out and flags unchanged.
- Opcode 0x3F -> err_illegal=1, res_out=0x0000.
- CMP reg=4 imm=4 -> Z=1, acc_out unchanged.
- POW imm=200 with rst pulsed on the 3rd EXEC cycle -> next cycle IDLE, cmd_ready=1, acc_out=0, no res_valid.
